// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Merges the ID-stage hazard
//   freeze, the EXE branch-taken flush and multi-cycle SRAM accesses from MEM
//   into per-stage hold/flush/bubble controls. Runs the SRAM wait FSM with a
//   timeout, and keeps saturating stall/flush performance counters.
//
// Parameters
//   TIMEOUT  max MEM_WAIT cycles without sram_ready before forced release (>=2)
//   CNT_W    width of the performance counters
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   hazard_i         data-hazard freeze request (ID stage)
//   branch_taken_i   branch resolved taken in EXE this cycle
//   mem_req_i        MEM-stage instruction accesses SRAM
//   sram_ready_i     SRAM access complete
//   cnt_clr_i        synchronous clear of counters and mem_timeout
//   hold_pc_o        PC keeps its value
//   hold_if_id_o     IF/ID keeps its value
//   flush_if_id_o    IF/ID loads a NOP
//   bubble_id_exe_o  ID/EXE loads a NOP
//   hold_exe_mem_o   ID/EXE, EXE/MEM and MEM/WB hold
//   sram_start_o     one-cycle pulse launching the SRAM access
//   mem_timeout_o    sticky: an access was released by timeout
//   stall_cnt_o      cycles with hold_pc set, saturating
//   flush_cnt_o      branch flushes performed, saturating
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             sram_ready_i,
  input  logic             cnt_clr_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             flush_if_id_o,
  output logic             bubble_id_exe_o,
  output logic             hold_exe_mem_o,
  output logic             sram_start_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;

  logic hold_pc, hold_if_id, flush_if_id, bubble_id_exe, hold_exe_mem, sram_start;
  logic release_w;
  logic timeout_hit;

  // Next state and stage controls
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    hold_pc       = 1'b0;
    hold_if_id    = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    hold_exe_mem  = 1'b0;
    sram_start    = 1'b0;
    release_w     = 1'b0;
    timeout_hit   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_req_i) begin
          // Hazard/branch are re-evaluated once the hold releases.
          sram_start   = 1'b1;
          hold_pc      = 1'b1;
          hold_if_id   = 1'b1;
          hold_exe_mem = 1'b1;
          state_d      = StMemWait;
          wait_cnt_d   = '0;
        end else if (branch_taken_i) begin
          // A concurrent hazard belongs to an instruction being flushed.
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (hazard_i) begin
          hold_pc       = 1'b1;
          hold_if_id    = 1'b1;
          bubble_id_exe = 1'b1;
        end
      end
      StMemWait: begin
        release_w    = sram_ready_i | (wait_cnt_q == WaitLast);
        hold_pc      = ~release_w;
        hold_if_id   = ~release_w;
        hold_exe_mem = ~release_w;
        if (release_w) begin
          state_d     = StRun;
          timeout_hit = ~sram_ready_i;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      default: state_d = StRun;
    endcase

    // Outputs are forced low for as long as reset is asserted.
    if (!rst_ni) begin
      hold_pc       = 1'b0;
      hold_if_id    = 1'b0;
      flush_if_id   = 1'b0;
      bubble_id_exe = 1'b0;
      hold_exe_mem  = 1'b0;
      sram_start    = 1'b0;
      timeout_hit   = 1'b0;
    end
  end

  // Performance counters and sticky timeout flag; clear wins over update.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (cnt_clr_i) begin
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
      mem_timeout_d = 1'b0;
    end else begin
      if (hold_pc && (stall_cnt_q != CntMax)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_if_id && (flush_cnt_q != CntMax)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if (timeout_hit) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign hold_pc_o       = hold_pc;
  assign hold_if_id_o    = hold_if_id;
  assign flush_if_id_o   = flush_if_id;
  assign bubble_id_exe_o = bubble_id_exe;
  assign hold_exe_mem_o  = hold_exe_mem;
  assign sram_start_o    = sram_start;
  assign mem_timeout_o   = mem_timeout_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (TIMEOUT=16, CNT_W=4).
// Inputs change 1 time unit after each rising edge; combinational outputs are
// sampled 4 units after the edge, registered outputs 1 unit after the edge.
module tb_pipeline_stall_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             hazard_i, branch_taken_i, mem_req_i, sram_ready_i, cnt_clr_i;
  logic             hold_pc_o, hold_if_id_o, flush_if_id_o, bubble_id_exe_o;
  logic             hold_exe_mem_o, sram_start_o, mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [5:0]       outs;

  int n_assert = 0;
  int n_fail   = 0;

  // {hold_pc, hold_if_id, flush_if_id, bubble_id_exe, hold_exe_mem, sram_start}
  localparam logic [5:0] ONone  = 6'b000000;
  localparam logic [5:0] OHaz   = 6'b110100;
  localparam logic [5:0] OBr    = 6'b001100;
  localparam logic [5:0] OStart = 6'b110011;
  localparam logic [5:0] OWait  = 6'b110010;

  pipeline_stall_ctrl #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .hazard_i       (hazard_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .sram_ready_i   (sram_ready_i),
    .cnt_clr_i      (cnt_clr_i),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .flush_if_id_o  (flush_if_id_o),
    .bubble_id_exe_o(bubble_id_exe_o),
    .hold_exe_mem_o (hold_exe_mem_o),
    .sram_start_o   (sram_start_o),
    .mem_timeout_o  (mem_timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign outs = {hold_pc_o, hold_if_id_o, flush_if_id_o, bubble_id_exe_o,
                 hold_exe_mem_o, sram_start_o};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with mem_req and hazard asserted
    rst_ni = 1'b0; hazard_i = 1'b1; branch_taken_i = 1'b0; mem_req_i = 1'b1;
    sram_ready_i = 1'b0; cnt_clr_i = 1'b0;
    #3;
    chk("rst_outs", 32'(outs), 32'(ONone));
    chk("rst_stall", 32'(stall_cnt_o), 0);
    chk("rst_flush", 32'(flush_cnt_o), 0);
    chk("rst_tmo", 32'(mem_timeout_o), 0);
    tick();
    tick();
    chk("rst_outs_hold", 32'(outs), 32'(ONone));
    rst_ni = 1'b1; hazard_i = 1'b0; mem_req_i = 1'b0;
    #3 chk("run_idle", 32'(outs), 32'(ONone));

    // 2. Two hazard cycles
    tick();
    hazard_i = 1'b1;
    #3 chk("haz_c1", 32'(outs), 32'(OHaz));
    tick();
    #3 chk("haz_c2", 32'(outs), 32'(OHaz));
    tick();
    hazard_i = 1'b0;
    chk("haz_stall", 32'(stall_cnt_o), 2);

    // 3. Branch beats hazard
    branch_taken_i = 1'b1; hazard_i = 1'b1;
    #3 chk("br_haz", 32'(outs), 32'(OBr));
    tick();
    branch_taken_i = 1'b0; hazard_i = 1'b0;
    chk("br_flush", 32'(flush_cnt_o), 1);
    chk("br_stall", 32'(stall_cnt_o), 2);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("clr_stall", 32'(stall_cnt_o), 0);
    chk("clr_flush", 32'(flush_cnt_o), 0);

    // 4. SRAM access, ready 3 cycles after start; branch ignored in MEM_WAIT
    mem_req_i = 1'b1; branch_taken_i = 1'b1;
    #3 chk("mem_start", 32'(outs), 32'(OStart));
    tick();
    #3 chk("mem_w0", 32'(outs), 32'(OWait));
    tick();
    #3 chk("mem_w1", 32'(outs), 32'(OWait));
    tick();
    sram_ready_i = 1'b1; mem_req_i = 1'b0; branch_taken_i = 1'b0;
    #3 chk("mem_rdy", 32'(outs), 32'(ONone));
    tick();
    sram_ready_i = 1'b0;
    chk("mem_stall", 32'(stall_cnt_o), 3);
    chk("mem_flush", 32'(flush_cnt_o), 0);
    #3 chk("mem_after", 32'(outs), 32'(ONone));

    // Back-to-back accesses
    tick();
    mem_req_i = 1'b1;
    #3 chk("b2b_start1", 32'(outs), 32'(OStart));
    tick();
    sram_ready_i = 1'b1;
    #3 chk("b2b_rel1", 32'(outs), 32'(ONone));
    tick();
    sram_ready_i = 1'b0;
    #3 chk("b2b_start2", 32'(outs), 32'(OStart));
    tick();
    sram_ready_i = 1'b1; mem_req_i = 1'b0;
    #3 chk("b2b_rel2", 32'(outs), 32'(ONone));
    tick();
    sram_ready_i = 1'b0;
    chk("b2b_stall", 32'(stall_cnt_o), 5);
    chk("b2b_tmo", 32'(mem_timeout_o), 0);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;

    // 5. Timeout: release in the 16th MEM_WAIT cycle
    mem_req_i = 1'b1;
    #3 chk("tmo_start", 32'(outs), 32'(OStart));
    tick();
    mem_req_i = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      #3 chk($sformatf("tmo_w%0d", i), 32'(outs), 32'(OWait));
      tick();
    end
    #3 chk("tmo_rel", 32'(outs), 32'(ONone));
    chk("tmo_flag_pre", 32'(mem_timeout_o), 0);
    tick();
    chk("tmo_flag", 32'(mem_timeout_o), 1);
    chk("tmo_stall_sat", 32'(stall_cnt_o), 15);
    #3 chk("tmo_run", 32'(outs), 32'(ONone));
    tick();
    chk("tmo_sticky", 32'(mem_timeout_o), 1);
    cnt_clr_i = 1'b1; hazard_i = 1'b1;
    #3 chk("clr_haz_outs", 32'(outs), 32'(OHaz));
    tick();
    cnt_clr_i = 1'b0; hazard_i = 1'b0;
    chk("tmo_clr", 32'(mem_timeout_o), 0);
    chk("tmo_clr_stall", 32'(stall_cnt_o), 0);

    // 6. Stall counter saturation, clear wins over increment
    hazard_i = 1'b1;
    repeat (20) tick();
    chk("sat_stall", 32'(stall_cnt_o), 15);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("sat_clr", 32'(stall_cnt_o), 0);
    tick();
    hazard_i = 1'b0;
    chk("sat_resume", 32'(stall_cnt_o), 1);

    // Flush counter saturation
    branch_taken_i = 1'b1;
    repeat (17) tick();
    branch_taken_i = 1'b0;
    chk("sat_flush", 32'(flush_cnt_o), 15);
    chk("sat_flush_stall", 32'(stall_cnt_o), 1);

    // Reset in the middle of an access
    mem_req_i = 1'b1;
    tick();
    mem_req_i = 1'b0;
    #3 chk("rstmid_wait", 32'(outs), 32'(OWait));
    #1 rst_ni = 1'b0;
    #1 chk("rstmid_outs", 32'(outs), 32'(ONone));
    chk("rstmid_flush", 32'(flush_cnt_o), 0);
    tick();
    rst_ni = 1'b1;
    #3 chk("rstmid_run", 32'(outs), 32'(ONone));
    tick();
    #3 chk("rstmid_idle", 32'(outs), 32'(ONone));
    mem_req_i = 1'b1;
    #1 chk("rstmid_restart", 32'(outs), 32'(OStart));
    tick();
    mem_req_i = 1'b0;
    sram_ready_i = 1'b1;
    tick();
    sram_ready_i = 1'b0;
    chk("rstmid_stall", 32'(stall_cnt_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
